// File: rtl/numa_bank_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// numa_bank_arbiter_pkg : width helpers shared by the TCDM bank arbiter slice
// Rev 1.0
// ----------------------------------------------------------------------------
package numa_bank_arbiter_pkg;

  function automatic int credit_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int port_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/numa_bank_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// numa_bank_arbiter_if / numa_bank_mem_if : port-side and bank-side bundles
// Rev 1.0
// ----------------------------------------------------------------------------
interface numa_bank_arbiter_if #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_MEM_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int IDX_WIDTH      = 5
);
  logic [NUM_PORTS-1:0]                     req_i;
  logic [NUM_PORTS-1:0]                     gnt_o;
  logic [NUM_PORTS-1:0][ADDR_MEM_WIDTH-1:0] add_i;
  logic [NUM_PORTS-1:0]                     wen_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i;
  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]       be_i;
  logic [NUM_PORTS-1:0][IDX_WIDTH-1:0]      idx_i;
  logic [NUM_PORTS-1:0]                     vld_o;
  logic [NUM_PORTS-1:0]                     rdy_i;
  logic [DATA_WIDTH-1:0]                    rdata_o;
  logic [IDX_WIDTH-1:0]                     idx_o;

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i, idx_i, rdy_i,
    input  gnt_o, vld_o, rdata_o, idx_o
  );
  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i, idx_i, rdy_i,
    output gnt_o, vld_o, rdata_o, idx_o
  );
endinterface

interface numa_bank_mem_if #(
  parameter int ADDR_MEM_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8
);
  logic                      mem_req_o;
  logic [ADDR_MEM_WIDTH-1:0] mem_add_o;
  logic                      mem_wen_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic [BE_WIDTH-1:0]       mem_be_o;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;

  modport master (
    output mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
    input  mem_rdata_i
  );
  modport slave (
    input  mem_req_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
    output mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/numa_bank_arbiter_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// numa_rr_arbiter : round-robin picker, scan starts at the registered pointer
// Rev 1.0
// ----------------------------------------------------------------------------
module numa_rr_arbiter
  import numa_bank_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int PTR_W     = port_id_width(NUM_PORTS)
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_en,
  input  wire logic [NUM_PORTS-1:0] i_req,
  output logic      [NUM_PORTS-1:0] o_gnt,
  output logic      [PTR_W-1:0]     o_win,
  output logic                      o_valid
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_cand;
  int               w_sum;

  always_comb begin
    o_gnt   = '0;
    o_win   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    w_sum   = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      w_sum = int'(r_ptr) + off;
      if (w_sum >= NUM_PORTS) w_sum = w_sum - NUM_PORTS;
      w_cand = w_sum[PTR_W-1:0];
      if (i_en && !o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_win   = w_cand;
      end
    end
    if (o_valid) o_gnt[o_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (o_win == PTR_W'(NUM_PORTS - 1)) ? '0 : o_win + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/numa_bank_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// numa_bank_arbiter : credit-limited RR sharing of one TCDM bank, in-order responses
// Rev 1.0
// ----------------------------------------------------------------------------
module numa_bank_arbiter
  import numa_bank_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_MEM_WIDTH  = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int IDX_WIDTH       = 5,
  parameter int NUM_OUTSTANDING = 2
) (
  input wire logic          clk_i,
  input wire logic          rst_i,
  numa_bank_arbiter_if.slave bus,
  numa_bank_mem_if.master    mem
);

  localparam int CNT_W = credit_width(NUM_OUTSTANDING);
  localparam int PID_W = port_id_width(NUM_PORTS);
  localparam int QA_W  = port_id_width(NUM_OUTSTANDING);

  typedef struct packed {
    logic [PID_W-1:0]      port;
    logic [IDX_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] rdata;
  } resp_entry_t;

  function automatic logic [QA_W-1:0] qa_next(input logic [QA_W-1:0] p);
    return (p == QA_W'(NUM_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic             r_inflight;
  logic [PID_W-1:0] r_port;
  logic [IDX_WIDTH-1:0] r_idx;
  resp_entry_t      r_fifo [NUM_OUTSTANDING];
  logic [QA_W-1:0]  r_wptr;
  logic [QA_W-1:0]  r_rptr;
  logic [CNT_W-1:0] r_usage;

  logic             w_arb_en;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [PID_W-1:0] w_win;
  logic             w_grant;
  resp_entry_t      w_push_entry;
  resp_entry_t      w_head;
  logic             w_empty;
  logic             w_head_vld;
  logic             w_pop;
  logic             w_store;
  logic             w_drain;

  // Credits cover both the in-flight beat and queued entries, so the queue cannot overflow.
  assign w_arb_en = !rst_i && (r_cnt < CNT_W'(NUM_OUTSTANDING));

  numa_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_en    (w_arb_en),
    .i_req   (bus.req_i),
    .o_gnt   (w_gnt),
    .o_win   (w_win),
    .o_valid (w_grant)
  );

  assign bus.gnt_o       = w_gnt;
  assign mem.mem_req_o   = w_grant;
  assign mem.mem_add_o   = w_grant ? bus.add_i[w_win]   : '0;
  assign mem.mem_wen_o   = w_grant ? bus.wen_i[w_win]   : 1'b0;
  assign mem.mem_wdata_o = w_grant ? bus.wdata_i[w_win] : '0;
  assign mem.mem_be_o    = w_grant ? bus.be_i[w_win]    : '0;

  // Fall-through on empty: the bank beat can be presented and popped in its arrival cycle.
  assign w_push_entry = '{port: r_port, idx: r_idx, rdata: mem.mem_rdata_i};
  assign w_empty      = (r_usage == '0);
  assign w_head       = w_empty ? w_push_entry : r_fifo[r_rptr];
  assign w_head_vld   = !rst_i && (!w_empty || r_inflight);
  assign w_pop        = w_head_vld && bus.rdy_i[w_head.port];
  assign w_store      = r_inflight && !(w_empty && w_pop);
  assign w_drain      = w_pop && !w_empty;

  assign bus.vld_o   = w_head_vld ? (NUM_PORTS'(1) << w_head.port) : '0;
  assign bus.rdata_o = w_head_vld ? w_head.rdata : '0;
  assign bus.idx_o   = w_head_vld ? w_head.idx   : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_port     <= '0;
      r_idx      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_usage    <= '0;
    end else begin
      r_inflight <= w_grant;
      if (w_grant) begin
        r_port <= w_win;
        r_idx  <= bus.idx_i[w_win];
      end
      r_cnt   <= r_cnt + CNT_W'(w_grant) - CNT_W'(w_pop);
      r_usage <= r_usage + CNT_W'(w_store) - CNT_W'(w_drain);
      if (w_store) r_wptr <= qa_next(r_wptr);
      if (w_drain) r_rptr <= qa_next(r_rptr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store) r_fifo[r_wptr] <= w_push_entry;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(w_gnt));
      assert ($onehot0(bus.vld_o));
      assert (r_cnt <= CNT_W'(NUM_OUTSTANDING));
      assert (!(w_store && (r_usage == CNT_W'(NUM_OUTSTANDING))));
      assert (r_cnt == r_usage + CNT_W'(r_inflight));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_numa_bank_arbiter.sv
`default_nettype none
// Randomised scoreboard bench for numa_bank_arbiter: a queue-based model predicts
// grants, bank traffic and in-order responses; a separate monitor pops and compares.
module tb_numa_bank_arbiter;

  localparam int NP = 2;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int IW = 5;
  localparam int NO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  numa_bank_arbiter_if #(.NUM_PORTS(NP), .ADDR_MEM_WIDTH(AW), .DATA_WIDTH(DW),
                         .BE_WIDTH(BW), .IDX_WIDTH(IW)) bus ();
  numa_bank_mem_if #(.ADDR_MEM_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) mem ();

  numa_bank_arbiter #(.NUM_PORTS(NP), .ADDR_MEM_WIDTH(AW), .DATA_WIDTH(DW),
                      .BE_WIDTH(BW), .IDX_WIDTH(IW), .NUM_OUTSTANDING(NO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .mem   (mem)
  );

  // ---------------- SRAM bank (environment) ----------------
  logic [DW-1:0] sram   [4096];
  logic [DW-1:0] golden [4096];
  logic [DW-1:0] sram_rd;
  assign mem.mem_rdata_i = sram_rd;

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5C3_0000;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram[i]   = init_word(i);
      golden[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (mem.mem_req_o) begin
      if (mem.mem_wen_o) begin
        sram[mem.mem_add_o] <= merge(sram[mem.mem_add_o], mem.mem_wdata_o, mem.mem_be_o);
        sram_rd <= 32'hDEAD_BEEF;
      end else begin
        sram_rd <= sram[mem.mem_add_o];
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int            port;
    int            idx;
    bit            is_load;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   rr_ptr  = 0;
  int   cycle   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: actual %0h required %0h", name, cycle, act, exp);
  endtask

  // Grant side: the model owns the RR pointer and the outstanding count (= queue size).
  initial begin
    int   win;
    int   p;
    int   a;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs", {bus.gnt_o, bus.vld_o, mem.mem_req_o}, 64'd0);
        q.delete();
        rr_ptr = 0;
      end else begin
        win = -1;
        if (q.size() < NO) begin
          for (int k = 0; k < NP; k++) begin
            p = (rr_ptr + k) % NP;
            if (win < 0 && bus.req_i[p]) win = p;
          end
        end
        check("gnt", 64'(bus.gnt_o), (win >= 0) ? 64'(1) << win : 64'd0);
        if (win >= 0) begin
          a = int'(bus.add_i[win]);
          check("mem_bus",
                {mem.mem_req_o, mem.mem_add_o, mem.mem_wen_o, mem.mem_wdata_o, mem.mem_be_o},
                {1'b1, bus.add_i[win], bus.wen_i[win], bus.wdata_i[win], bus.be_i[win]});
          e.port    = win;
          e.idx     = int'(bus.idx_i[win]);
          e.is_load = !bus.wen_i[win];
          e.data    = golden[a];
          e.cyc     = cycle;
          if (bus.wen_i[win]) golden[a] = merge(golden[a], bus.wdata_i[win], bus.be_i[win]);
          q.push_back(e);
          rr_ptr = (win + 1) % NP;
        end else begin
          check("mem_idle", 64'(mem.mem_req_o), 64'd0);
        end
      end
    end
  end

  // Response side: head of queue becomes visible the cycle after its grant.
  initial begin
    logic [NP-1:0] exp_vld;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        exp_vld = '0;
        if (q.size() > 0 && q[0].cyc < cycle) exp_vld[q[0].port] = 1'b1;
        check("vld", 64'(bus.vld_o), 64'(exp_vld));
        if (exp_vld != '0) begin
          check("resp_idx", 64'(bus.idx_o), 64'(q[0].idx));
          if (q[0].is_load) check("resp_data", 64'(bus.rdata_o), 64'(q[0].data));
          if ((exp_vld & bus.rdy_i) != '0) void'(q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_inputs(input logic [NP-1:0] req, input logic [NP-1:0] wen,
                            input logic [NP-1:0] rdy);
    bus.req_i = req;
    bus.wen_i = wen;
    bus.rdy_i = rdy;
    for (int p = 0; p < NP; p++) begin
      bus.add_i[p]   = AW'($urandom_range(0, 15));
      bus.wdata_i[p] = $urandom;
      bus.be_i[p]    = BW'($urandom_range(1, 15));
      bus.idx_i[p]   = IW'($urandom);
    end
  endtask

  task automatic drive(input logic [NP-1:0] req, input logic [NP-1:0] wen,
                       input logic [NP-1:0] rdy, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      set_inputs(req, wen, rdy);
    end
  endtask

  initial begin
    set_inputs('0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // continuous loads from both ports, always ready
    drive(2'b11, 2'b00, 2'b11, 20);
    drive(2'b00, 2'b00, 2'b11, 3);

    // credit exhaustion, single pop, resume
    drive(2'b01, 2'b00, 2'b00, 6);
    drive(2'b01, 2'b00, 2'b01, 1);
    drive(2'b01, 2'b00, 2'b00, 3);
    drive(2'b00, 2'b00, 2'b11, 4);

    // port 1 partial store then load of the same word
    @(posedge clk);
    #1;
    set_inputs(2'b10, 2'b10, 2'b11);
    bus.add_i[1] = 12'h03A;
    bus.be_i[1]  = 4'b0011;
    @(posedge clk);
    #1;
    set_inputs(2'b10, 2'b00, 2'b11);
    bus.add_i[1] = 12'h03A;
    drive(2'b00, 2'b00, 2'b11, 4);

    // head-of-line blocking behind a stalled port 0
    drive(2'b01, 2'b00, 2'b10, 1);
    drive(2'b10, 2'b00, 2'b10, 1);
    drive(2'b00, 2'b00, 2'b10, 4);
    drive(2'b00, 2'b00, 2'b11, 3);

    // reset with responses outstanding
    drive(2'b01, 2'b00, 2'b00, 4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_inputs(2'b11, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_inputs(2'b11, 2'b00, 2'b11);
    drive(2'b11, 2'b00, 2'b11, 3);
    drive(2'b00, 2'b00, 2'b11, 3);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(NP'($urandom), NP'($urandom), NP'($urandom | $urandom), 1);
    end
    drive(2'b00, 2'b00, 2'b11, 6);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
